// File: rtl/seq_pkg.sv
// Shared widths, opcodes and FSM states for the instruction sequencer.
package seq_pkg;
    localparam int unsigned OPW = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned IW  = 20;
    localparam int unsigned AW  = 4;
    localparam int unsigned SW  = 8;

    localparam logic [OPW-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW-1:0] OP_JZ   = 4'h1;
    localparam logic [OPW-1:0] OP_JMP  = 4'h7;
    localparam logic [OPW-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/program_buffer.sv
// Program word store: synchronous write, asynchronous read, contents survive reset.
module program_buffer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);
    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_sequencer.sv
// Fetches program words and issues them to the register datapath, resolving
// JZ/JMP/HALT locally; JZ spends one bubble cycle waiting for z_flag.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          z_flag,
    output logic [IW-1:0] instruction,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW-1:0] pc,
    output logic [SW-1:0] step_count
);
    localparam logic [IW-1:0] BUBBLE = {OP_NOP, (IW-OPW)'(0)};

    state_t          r_state;
    logic            r_branch_pending;
    logic [IW-1:0]   r_instruction;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;
    logic [AW-1:0]   r_pc;
    logic [SW-1:0]   r_step_count;

    logic [IW-1:0]   w_fetch;
    logic [OPW-1:0]  w_op;
    logic [AW-1:0]   w_pc_inc;
    logic [SW-1:0]   w_steps_next;
    logic            w_last_step;
    logic            w_we;

    assign load_ready   = (r_state != RUN);
    assign w_we         = load_valid & load_ready;
    assign w_op         = w_fetch[IW-1 -: OPW];
    assign w_pc_inc     = r_pc + AW'(1);
    assign w_steps_next = r_step_count + SW'(1);
    assign w_last_step  = (w_steps_next == SW'(MAX_STEPS));

    program_buffer #(
        .DEPTH (DEPTH)
    ) u_program_buffer (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (r_pc),
        .o_rdata (w_fetch)
    );

    // While a JZ is pending, r_instruction still holds its test word, so p2 is read back from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_branch_pending <= 1'b0;
            r_instruction    <= BUBBLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_timeout        <= 1'b0;
            r_pc             <= '0;
            r_step_count     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state          <= RUN;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_timeout        <= 1'b0;
                        r_branch_pending <= 1'b0;
                        r_instruction    <= BUBBLE;
                        r_pc             <= start_addr;
                        r_step_count     <= '0;
                    end
                end
                RUN: begin
                    if (r_branch_pending) begin
                        r_branch_pending <= 1'b0;
                        r_instruction    <= BUBBLE;
                        r_pc             <= z_flag ? r_instruction[AW-1:0] : w_pc_inc;
                    end else begin
                        r_step_count <= w_steps_next;
                        if (w_op == OP_HALT) begin
                            r_instruction <= BUBBLE;
                            r_state       <= DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end else begin
                            if (w_op == OP_JZ) begin
                                r_instruction <= {OP_NOP, w_fetch[2*PW-1:0]};
                            end else if (w_op == OP_JMP) begin
                                r_instruction <= BUBBLE;
                            end else begin
                                r_instruction <= w_fetch;
                            end

                            if (w_last_step) begin
                                r_state   <= DONE;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_timeout <= 1'b1;
                            end else if (w_op == OP_JZ) begin
                                r_branch_pending <= 1'b1;
                            end else if (w_op == OP_JMP) begin
                                r_pc <= w_fetch[AW-1:0];
                            end else begin
                                r_pc <= w_pc_inc;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instruction = r_instruction;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign pc          = r_pc;
    assign step_count  = r_step_count;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed + random program runs checked against a program-level interpreter with a toy datapath.
module tb_instruction_sequencer;
    localparam int MAXS = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic [3:0]  start_addr;
    logic        z_flag;
    logic [19:0] instruction;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [3:0]  pc;
    logic [7:0]  step_count;

    int n_checks = 0;
    int n_err    = 0;

    instruction_sequencer #(.DEPTH(16), .MAX_STEPS(MAXS)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .start_addr  (start_addr),
        .z_flag      (z_flag),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .pc          (pc),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    // Toy 4x9-bit datapath: op3 r[p1]=p2, op5 r[p1]-=p2; executes the word on the bus at each edge.
    logic [8:0] dp [4];
    logic       dp_wr = 1'b0;
    logic [1:0] dp_idx = 2'd0;
    logic [8:0] dp_val = 9'd0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) dp[i] <= 9'd0;
        end else if (dp_wr) begin
            dp[dp_idx] <= dp_val;
        end else if (instruction[19:16] == 4'h3) begin
            dp[instruction[9:8]] <= 9'(instruction[7:0]);
        end else if (instruction[19:16] == 4'h5) begin
            dp[instruction[9:8]] <= dp[instruction[9:8]] - 9'(instruction[7:0]);
        end
    end
    assign z_flag = (dp[instruction[9:8]] == 9'd0);

    // Reference: what the program should put on the bus, interpreted word by word.
    logic [19:0] mprog [16];
    logic [19:0] exp_q [$];
    int          exp_steps;
    logic        exp_to;
    logic [3:0]  exp_pc;

    task automatic model_run(input logic [3:0] s);
        logic [8:0]  mr [4];
        logic [3:0]  p;
        logic [19:0] w;
        for (int i = 0; i < 4; i++) mr[i] = dp[i];
        exp_q.delete();
        exp_to = 1'b0;
        exp_steps = 0;
        p = s;
        for (int n = 1; n <= MAXS; n++) begin
            w = mprog[p];
            exp_steps = n;
            if (w[19:16] == 4'hF) begin
                exp_q.push_back(20'h0);
                break;
            end
            if (w[19:16] == 4'h1)      exp_q.push_back({4'h0, w[15:0]});
            else if (w[19:16] == 4'h7) exp_q.push_back(20'h0);
            else begin
                exp_q.push_back(w);
                if (w[19:16] == 4'h3) mr[w[9:8]] = 9'(w[7:0]);
                if (w[19:16] == 4'h5) mr[w[9:8]] = mr[w[9:8]] - 9'(w[7:0]);
            end
            if (n == MAXS) begin
                exp_to = 1'b1;
                break;
            end
            if (w[19:16] == 4'h1) begin
                exp_q.push_back(20'h0);
                p = (mr[w[9:8]] == 9'd0) ? w[3:0] : p + 4'd1;
            end else if (w[19:16] == 4'h7) begin
                p = w[3:0];
            end else begin
                p = p + 4'd1;
            end
        end
        exp_pc = p;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [19:0] d);
        @(negedge clk);
        load_valid = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_valid = 1'b0;
        mprog[a] = d;
    endtask

    // Start a run, compare every bus word, then the end-of-run status.
    task automatic run_check(input string tag, input logic [3:0] s, input bit inject,
                             input bit ld_same, input logic [19:0] ld_d);
        @(negedge clk);
        start = 1'b1; start_addr = s;
        if (ld_same) begin
            load_valid = 1'b1; load_addr = s; load_data = ld_d;
        end
        @(posedge clk); #1;
        start = 1'b0;
        load_valid = 1'b0;
        if (ld_same) mprog[s] = ld_d;
        model_run(s);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (inject && k == 3) begin
                load_valid = 1'b1; load_addr = 4'd1; load_data = 20'h20102;
            end
            @(posedge clk); #1;
            if (inject && k == 3) begin
                chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end
            chk($sformatf("%s_bus%0d", tag, k), 32'(instruction), 32'(exp_q[k]));
        end
        chk({tag, "_done"},    32'(done),       32'd1);
        chk({tag, "_busyend"}, 32'(busy),       32'd0);
        chk({tag, "_steps"},   32'(step_count), 32'(exp_steps));
        chk({tag, "_timeout"}, 32'(timeout),    32'(exp_to));
        chk({tag, "_pc"},      32'(pc),         32'(exp_pc));
        chk({tag, "_ready"},   32'(load_ready), 32'd1);
    endtask

    logic [3:0] ops [8];

    initial begin
        ops[0] = 4'h0; ops[1] = 4'h3; ops[2] = 4'h5; ops[3] = 4'h1;
        ops[4] = 4'h7; ops[5] = 4'hF; ops[6] = 4'h2; ops[7] = 4'h5;
        reset = 1'b1; load_valid = 1'b0; load_addr = 4'd0; load_data = 20'h0;
        start = 1'b0; start_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_to",    32'(timeout),     32'd0);
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_steps", 32'(step_count),  32'd0);
        chk("rst_ready", 32'(load_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Straight-line program ending in HALT
        load_word(4'd0, 20'h30005);
        load_word(4'd1, 20'hF0000);
        run_check("t1", 4'd0, 1'b0, 1'b0, 20'h0);

        // Counted loop: JZ falls through once, then taken
        load_word(4'd0, 20'h50001);
        load_word(4'd1, 20'h10003);
        load_word(4'd2, 20'h70000);
        load_word(4'd3, 20'hF0000);
        @(negedge clk);
        dp_wr = 1'b1; dp_idx = 2'd0; dp_val = 9'd2;
        @(negedge clk);
        dp_wr = 1'b0;
        run_check("t2", 4'd0, 1'b0, 1'b0, 20'h0);

        // Self-loop hits the step limit; a write attempted mid-run must be dropped
        load_word(4'd0, 20'h70000);
        load_word(4'd1, 20'hF0000);
        run_check("t3", 4'd0, 1'b1, 1'b0, 20'h0);
        run_check("t4_reread", 4'd1, 1'b0, 1'b0, 20'h0);

        // Asynchronous reset mid-run, then the retained program runs again
        load_word(4'd0, 20'h30005);
        load_word(4'd1, 20'h50001);
        load_word(4'd2, 20'h70000);
        @(negedge clk);
        start = 1'b1; start_addr = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_instr", 32'(instruction), 32'd0);
        chk("t5_busy",  32'(busy),        32'd0);
        chk("t5_pc",    32'(pc),          32'd0);
        chk("t5_steps", 32'(step_count),  32'd0);
        chk("t5_ready", 32'(load_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_check("t5_rerun", 4'd0, 1'b0, 1'b0, 20'h0);

        // PC wraps 15 -> 0
        load_word(4'd15, 20'h30101);
        load_word(4'd0,  20'hF0000);
        run_check("t6", 4'd15, 1'b0, 1'b0, 20'h0);

        // Random programs; the last round loads the first word in the start cycle
        for (int r = 0; r < 4; r++) begin
            logic [19:0] w;
            logic [3:0]  s;
            for (int a = 0; a < 16; a++) begin
                w = {ops[$urandom_range(0, 7)], 8'($urandom), 8'($urandom)};
                load_word(4'(a), w);
            end
            s = 4'($urandom);
            w = {ops[$urandom_range(0, 3)], 8'($urandom), 8'($urandom)};
            run_check($sformatf("rnd%0d", r), s, 1'b0, (r == 3), w);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
